scan_mux: RTL and testbench

Parametrised N-to-1 registered multiplexer with an optional built-in channel scanner. It generalises the fixed 8x1 two-input mux tree to any channel count and data width. It adds a registered output, a channel tag and valid flag, and an auto-scan mode that walks through all inputs with a programmable dwell time. It sits between a bank of parallel sources and a single serial consumer, such as a display, logger or test probe.

---
 rtl/scan_mux.sv | 87 ++++++++
 tb/tb_scan_mux.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// scan_mux: N-to-1 registered multiplexer with an auto-scan channel walker.
// The output register carries the data, its channel tag, validity and a wrap pulse.
module scan_mux #(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 8,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      hold,
   input  logic [7:0]                dwell,
   output logic [WIDTH-1:0]          data_out,
   output logic [SEL_W-1:0]          chan_out,
   output logic                      out_valid,
   output logic                      wrap
);

   localparam logic [SEL_W:0]   CH_N = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0] scan_ptr;
   logic [7:0]       dwell_cnt;
   logic [SEL_W-1:0] ch;
   logic [WIDTH-1:0] mux_out;
   logic             ch_ok;
   logic             adv;

   always_comb begin
      ch    = mode ? scan_ptr : sel_in;
      ch_ok = {1'b0, ch} < CH_N;
      adv   = mode && !hold && (dwell_cnt >= dwell);
   end

   // Binary tree of 2:1 stages; leaf index equals the select code and
   // leaves past the last real channel read as zero.
   genvar l, i;
   generate
      for (l = 0; l <= SEL_W; l++) begin : lvl
         logic [WIDTH-1:0] node [1<<l];
         for (i = 0; i < (1 << l); i++) begin : n
            if (l == SEL_W) begin : leaf
               if (i < CHANNELS) begin : real_ch
                  assign node[i] = data_in[i*WIDTH +: WIDTH];
               end else begin : pad_ch
                  assign node[i] = '0;
               end
            end else begin : mx
               assign node[i] = ch[SEL_W-1-l] ? lvl[l+1].node[2*i+1]
                                              : lvl[l+1].node[2*i];
            end
         end
      end
   endgenerate

   assign mux_out = lvl[0].node[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out  <= '0;
         chan_out  <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         scan_ptr  <= '0;
         dwell_cnt <= '0;
      end else begin
         data_out  <= mux_out;
         chan_out  <= ch;
         out_valid <= ch_ok;
         wrap      <= adv && (scan_ptr == LAST);
         if (!mode) begin
            scan_ptr  <= '0;
            dwell_cnt <= '0;
         end else if (!hold) begin
            if (adv) begin
               dwell_cnt <= '0;
               scan_ptr  <= (scan_ptr == LAST) ? '0 : scan_ptr + SEL_W'(1);
            end else begin
               dwell_cnt <= dwell_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: scoreboard bench driving an 8-channel and a 5-channel instance
// in lockstep against a behavioural model of the scan/select rules.
module tb_scan_mux;

   typedef struct packed {
      logic [3:0] d;
      logic [2:0] c;
      logic       v;
      logic       w;
   } res_t;

   typedef struct packed {
      res_t a;
      res_t b;
   } pair_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [2:0]  sel;
   logic        hold;
   logic [7:0]  dwell;
   logic [3:0]  da [8];
   logic [31:0] din_a;
   logic [19:0] din_b;

   logic [3:0] a_d, b_d;
   logic [2:0] a_c, b_c;
   logic       a_v, b_v, a_w, b_w;

   int errors = 0;
   int checks = 0;
   int pa, ca, pb, cb;
   pair_t sbq [$];
   bit done = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      din_a = '0;
      din_b = '0;
      for (int k = 0; k < 8; k++) din_a[k*4 +: 4] = da[k];
      for (int k = 0; k < 5; k++) din_b[k*4 +: 4] = da[k];
   end

   scan_mux #(.WIDTH(4), .CHANNELS(8)) dut_a (
      .clk(clk), .rst(rst), .data_in(din_a), .mode(mode),
      .sel_in(sel), .hold(hold), .dwell(dwell),
      .data_out(a_d), .chan_out(a_c), .out_valid(a_v), .wrap(a_w)
   );

   scan_mux #(.WIDTH(4), .CHANNELS(5)) dut_b (
      .clk(clk), .rst(rst), .data_in(din_b), .mode(mode),
      .sel_in(sel), .hold(hold), .dwell(dwell),
      .data_out(b_d), .chan_out(b_c), .out_valid(b_v), .wrap(b_w)
   );

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference: the channel on show is the pointer (auto) or the select
   // (manual); in auto the pointer moves on once dwell+1 cycles are spent.
   task automatic model(input int n, inout int ptr, inout int cnt,
                        output res_t r);
      int ch;
      bit adv;
      r = '0;
      if (rst) begin
         ptr = 0;
         cnt = 0;
         return;
      end
      ch  = mode ? ptr : int'(sel);
      r.c = 3'(ch);
      r.v = (ch < n);
      r.d = (ch < n) ? da[ch] : 4'd0;
      adv = mode && !hold && (cnt >= int'(dwell));
      r.w = adv && (ptr == n - 1);
      if (!mode) begin
         ptr = 0;
         cnt = 0;
      end else if (!hold) begin
         if (adv) begin
            cnt = 0;
            ptr = (ptr + 1) % n;
         end else begin
            cnt++;
         end
      end
   endtask

   task automatic step();
      pair_t e;
      model(8, pa, ca, e.a);
      model(5, pb, cb, e.b);
      @(posedge clk);
      sbq.push_back(e);
      #1;
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         pair_t e;
         e = sbq.pop_front();
         chk("a.data",  int'(a_d), int'(e.a.d));
         chk("a.chan",  int'(a_c), int'(e.a.c));
         chk("a.valid", int'(a_v), int'(e.a.v));
         chk("a.wrap",  int'(a_w), int'(e.a.w));
         chk("b.data",  int'(b_d), int'(e.b.d));
         chk("b.chan",  int'(b_c), int'(e.b.c));
         chk("b.valid", int'(b_v), int'(e.b.v));
         chk("b.wrap",  int'(b_w), int'(e.b.w));
      end
   end

   initial begin
      int guard;
      rst   = 1'b1;
      mode  = 1'b0;
      sel   = '0;
      hold  = 1'b0;
      dwell = 8'd0;
      pa = 0; ca = 0; pb = 0; cb = 0;
      for (int k = 0; k < 8; k++) da[k] = 4'(k + 1);
      #2;
      repeat (2) step();
      rst = 1'b0;

      // manual select sweep; 5..7 are illegal on the 5-channel instance
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         step();
      end

      // auto scan, one cycle per channel
      mode = 1'b1;
      dwell = 8'd0;
      repeat (20) step();

      // auto scan, three cycles per channel
      mode = 1'b0;
      step();
      mode = 1'b1;
      dwell = 8'd2;
      repeat (35) step();

      // reset mid-scan, then resume
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (12) step();

      // hold on channel 3 while its data changes
      mode = 1'b0;
      step();
      mode = 1'b1;
      dwell = 8'd3;
      guard = 0;
      while (!(pa == 3 && ca == 1) && guard < 100) begin
         step();
         guard++;
      end
      chk("hold.reach", guard < 100 ? 1 : 0, 1);
      hold = 1'b1;
      repeat (2) step();
      da[3] = 4'd9;
      repeat (3) step();
      hold = 1'b0;
      repeat (10) step();
      da[3] = 4'd4;

      // mode 1 -> 0 -> 1 mid-scan
      repeat (5) step();
      mode = 1'b0;
      step();
      mode = 1'b1;
      repeat (8) step();

      // lower dwell mid-dwell
      mode = 1'b0;
      dwell = 8'd10;
      step();
      mode = 1'b1;
      guard = 0;
      while (ca != 5 && guard < 50) begin
         step();
         guard++;
      end
      chk("dwell.reach", guard < 50 ? 1 : 0, 1);
      dwell = 8'd1;
      repeat (6) step();

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         rst  = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         sel  = 3'($urandom_range(0, 7));
         hold = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            da[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
         step();
      end
      rst = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("sb.drain", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
